// File: rtl/sim_end_ctrl.sv
// sim_end_ctrl
// Decides when a simulation run is over and why. Three ways to end a run:
//   * an error strobe from any source. Further errors are still collected
//     during a short drain window before done rises.
//   * a halt from any commit channel. This is the only way to end with pass=1.
//   * the timeout expiring. The timeout is either absolute, or in progress
//     mode it restarts on every commit.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset; also captures timeout_cfg
//   commit_valid per-channel commit strobes (popcount added to commit_cnt)
//   halt         per-channel halt requests
//   err          per-source error strobes
//   timeout_cfg  timeout load value, sampled only while rst=1 (0 = disabled)
//   done         sticky end-of-simulation flag
//   done_pulse   one-cycle strobe on the first cycle of done
//   pass         sticky: run ended by halt with no error
//   cause        00 none, 01 halt, 10 error, 11 timeout
//   err_src      OR of every error source seen since reset
//   halt_ch      lowest-index channel that raised the ending halt
//   commit_cnt   saturating count of committed instructions
module sim_end_ctrl #(
    parameter int NUM_CH        = 8,
    parameter int NUM_ERR       = 3,
    parameter int TMO_W         = 32,
    parameter int CNT_W         = 32,
    parameter int DRAIN_CYCLES  = 5,
    parameter int PROGRESS_MODE = 0,
    localparam int HCW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CH-1:0]  commit_valid,
    input  logic [NUM_CH-1:0]  halt,
    input  logic [NUM_ERR-1:0] err,
    input  logic [TMO_W-1:0]   timeout_cfg,
    output logic               done,
    output logic               done_pulse,
    output logic               pass,
    output logic [1:0]         cause,
    output logic [NUM_ERR-1:0] err_src,
    output logic [HCW-1:0]     halt_ch,
    output logic [CNT_W-1:0]   commit_cnt
);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t             state, state_next;
    logic [TMO_W-1:0]   cfg_q;
    logic [TMO_W-1:0]   timer;
    logic [7:0]         drain_cnt;
    logic               done_q;
    logic               pass_q;
    logic [1:0]         cause_q;
    logic [NUM_ERR-1:0] err_src_q;
    logic [HCW-1:0]     halt_ch_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               any_err;
    logic               any_halt;
    logic               tmo_hit;
    logic [CNT_W:0]     cnt_sum;

    // Scan from the top down so the lowest set index wins.
    function automatic logic [HCW-1:0] lowest_idx(input logic [NUM_CH-1:0] v);
        logic [HCW-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (v[i]) r = HCW'(i);
        end
        return r;
    endfunction

    function automatic logic [CNT_W:0] popcount(input logic [NUM_CH-1:0] v);
        logic [CNT_W:0] s;
        s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            s = s + {{CNT_W{1'b0}}, v[i]};
        end
        return s;
    endfunction

    assign any_err  = |err;
    assign any_halt = |halt;
    // A stored config of zero means the timeout is disabled.
    assign tmo_hit  = (cfg_q != '0) && (timer == '0);
    // One extra bit catches overflow so the counter can saturate.
    assign cnt_sum  = {1'b0, cnt_q} + popcount(commit_valid);

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    // Error beats halt beats timeout when several happen in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (any_err)
                    state_next = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
                else if (any_halt || tmo_hit)
                    state_next = DONE;
            end
            DRAIN: begin
                // drain_cnt holds the number of drain cycles still to go,
                // including the current one.
                if (drain_cnt <= 8'd1) state_next = DONE;
            end
            DONE:    state_next = DONE;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        done       = (state == DONE);
        done_pulse = (state == DONE) && !done_q;
        pass       = pass_q;
        cause      = cause_q;
        err_src    = err_src_q;
        halt_ch    = halt_ch_q;
        commit_cnt = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q     <= timeout_cfg;
            timer     <= timeout_cfg;
            drain_cnt <= 8'(DRAIN_CYCLES);
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            cause_q   <= 2'b00;
            err_src_q <= '0;
            halt_ch_q <= '0;
            cnt_q     <= '0;
        end else begin
            done_q <= (state == DONE);
            case (state)
                RUN: begin
                    cnt_q <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
                    if (any_err) begin
                        err_src_q <= err_src_q | err;
                        cause_q   <= 2'b10;
                    end else if (any_halt) begin
                        cause_q   <= 2'b01;
                        pass_q    <= 1'b1;
                        halt_ch_q <= lowest_idx(halt);
                    end else if (tmo_hit) begin
                        cause_q   <= 2'b11;
                    end
                    // In progress mode any commit restarts the timeout window.
                    if ((PROGRESS_MODE != 0) && (|commit_valid))
                        timer <= cfg_q;
                    else if (timer != '0)
                        timer <= timer - TMO_W'(1);
                end
                DRAIN: begin
                    cnt_q     <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
                    err_src_q <= err_src_q | err;
                    if (drain_cnt != 8'd0) drain_cnt <= drain_cnt - 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_end_ctrl.sv
// tb_sim_end_ctrl
// Directed bench for sim_end_ctrl. It runs two instances side by side on
// shared inputs:
//   dut0  default parameters
//   dut1  PROGRESS_MODE=1, DRAIN_CYCLES=0, CNT_W=4
// Cycle numbering: cycle 0 is the first cycle after rst is released.
// Inputs are driven and outputs are sampled 1 time unit after each rising edge.
module tb_sim_end_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  commit_valid;
    logic [7:0]  halt;
    logic [2:0]  err;
    logic [31:0] timeout_cfg;

    logic        done0, done_pulse0, pass0;
    logic [1:0]  cause0;
    logic [2:0]  err_src0;
    logic [2:0]  halt_ch0;
    logic [31:0] commit_cnt0;

    logic        done1, done_pulse1, pass1;
    logic [1:0]  cause1;
    logic [2:0]  err_src1;
    logic [2:0]  halt_ch1;
    logic [3:0]  commit_cnt1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sim_end_ctrl dut0 (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .halt(halt),
        .err(err), .timeout_cfg(timeout_cfg), .done(done0),
        .done_pulse(done_pulse0), .pass(pass0), .cause(cause0),
        .err_src(err_src0), .halt_ch(halt_ch0), .commit_cnt(commit_cnt0)
    );

    sim_end_ctrl #(.PROGRESS_MODE(1), .DRAIN_CYCLES(0), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .halt(halt),
        .err(err), .timeout_cfg(timeout_cfg), .done(done1),
        .done_pulse(done_pulse1), .pass(pass1), .cause(cause1),
        .err_src(err_src1), .halt_ch(halt_ch1), .commit_cnt(commit_cnt1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] cfg);
        rst          = 1'b1;
        timeout_cfg  = cfg;
        commit_valid = '0;
        halt         = '0;
        err          = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset(32'd100);
        checks++; if (done0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%0b exp=0", done0); end
        checks++; if (done_pulse0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulse got=%0b exp=0", done_pulse0); end
        checks++; if (pass0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_pass got=%0b exp=0", pass0); end
        checks++; if (cause0 !== 2'b00) begin errors++; $display("[TB] FAIL reset_cause got=%b exp=00", cause0); end
        checks++; if (err_src0 !== 3'b000) begin errors++; $display("[TB] FAIL reset_err_src got=%b exp=000", err_src0); end
        checks++; if (halt_ch0 !== 3'd0) begin errors++; $display("[TB] FAIL reset_halt_ch got=%0d exp=0", halt_ch0); end
        checks++; if (commit_cnt0 !== 32'd0) begin errors++; $display("[TB] FAIL reset_cnt got=%0d exp=0", commit_cnt0); end
    endtask

    task automatic test_halt;
        do_reset(32'd100);
        commit_valid = 8'h03;
        repeat (3) tick();
        commit_valid = 8'h00;
        checks++; if (done0 !== 1'b0) begin errors++; $display("[TB] FAIL halt_early_done got=%0b exp=0", done0); end
        halt = 8'h24;
        tick();
        halt = 8'h00;
        checks++; if (done0 !== 1'b1) begin errors++; $display("[TB] FAIL halt_done got=%0b exp=1", done0); end
        checks++; if (done_pulse0 !== 1'b1) begin errors++; $display("[TB] FAIL halt_pulse got=%0b exp=1", done_pulse0); end
        checks++; if (pass0 !== 1'b1) begin errors++; $display("[TB] FAIL halt_pass got=%0b exp=1", pass0); end
        checks++; if (cause0 !== 2'b01) begin errors++; $display("[TB] FAIL halt_cause got=%b exp=01", cause0); end
        checks++; if (halt_ch0 !== 3'd2) begin errors++; $display("[TB] FAIL halt_ch got=%0d exp=2", halt_ch0); end
        checks++; if (commit_cnt0 !== 32'd6) begin errors++; $display("[TB] FAIL halt_cnt got=%0d exp=6", commit_cnt0); end
        tick();
        checks++; if (done_pulse0 !== 1'b0) begin errors++; $display("[TB] FAIL halt_pulse_drop got=%0b exp=0", done_pulse0); end
        checks++; if (done0 !== 1'b1) begin errors++; $display("[TB] FAIL halt_done_sticky got=%0b exp=1", done0); end
        // DONE must ignore every input.
        err = 3'b111; halt = 8'h01; commit_valid = 8'hFF;
        tick();
        tick();
        err = '0; halt = '0; commit_valid = '0;
        checks++; if (cause0 !== 2'b01) begin errors++; $display("[TB] FAIL absorb_cause got=%b exp=01", cause0); end
        checks++; if (err_src0 !== 3'b000) begin errors++; $display("[TB] FAIL absorb_err_src got=%b exp=000", err_src0); end
        checks++; if (commit_cnt0 !== 32'd6) begin errors++; $display("[TB] FAIL absorb_cnt got=%0d exp=6", commit_cnt0); end
        checks++; if (halt_ch0 !== 3'd2) begin errors++; $display("[TB] FAIL absorb_halt_ch got=%0d exp=2", halt_ch0); end
    endtask

    task automatic test_error_drain;
        do_reset(32'd0);
        for (int c = 0; c <= 18; c++) begin
            checks++; if (done0 !== logic'(c >= 16)) begin errors++; $display("[TB] FAIL drain_done c=%0d got=%0b exp=%0b", c, done0, c >= 16); end
            checks++; if (done_pulse0 !== logic'(c == 16)) begin errors++; $display("[TB] FAIL drain_pulse c=%0d got=%0b exp=%0b", c, done_pulse0, c == 16); end
            checks++; if (done1 !== logic'(c >= 11)) begin errors++; $display("[TB] FAIL nodrain_done c=%0d got=%0b exp=%0b", c, done1, c >= 11); end
            err  = (c == 10) ? 3'b010 : ((c == 12) ? 3'b100 : 3'b000);
            halt = (c == 13) ? 8'h01 : 8'h00;
            tick();
        end
        err = '0; halt = '0;
        checks++; if (cause0 !== 2'b10) begin errors++; $display("[TB] FAIL drain_cause got=%b exp=10", cause0); end
        checks++; if (pass0 !== 1'b0) begin errors++; $display("[TB] FAIL drain_pass got=%0b exp=0", pass0); end
        checks++; if (err_src0 !== 3'b110) begin errors++; $display("[TB] FAIL drain_err_src got=%b exp=110", err_src0); end
        checks++; if (halt_ch0 !== 3'd0) begin errors++; $display("[TB] FAIL drain_halt_ch got=%0d exp=0", halt_ch0); end
        checks++; if (cause1 !== 2'b10) begin errors++; $display("[TB] FAIL nodrain_cause got=%b exp=10", cause1); end
        checks++; if (err_src1 !== 3'b010) begin errors++; $display("[TB] FAIL nodrain_err_src got=%b exp=010", err_src1); end
    endtask

    task automatic test_abs_timeout;
        do_reset(32'd20);
        commit_valid = 8'h01;
        for (int c = 0; c <= 23; c++) begin
            checks++; if (done0 !== logic'(c >= 21)) begin errors++; $display("[TB] FAIL abs_tmo_done c=%0d got=%0b exp=%0b", c, done0, c >= 21); end
            tick();
        end
        commit_valid = '0;
        checks++; if (cause0 !== 2'b11) begin errors++; $display("[TB] FAIL abs_tmo_cause got=%b exp=11", cause0); end
        checks++; if (pass0 !== 1'b0) begin errors++; $display("[TB] FAIL abs_tmo_pass got=%0b exp=0", pass0); end
        checks++; if (commit_cnt0 !== 32'd21) begin errors++; $display("[TB] FAIL abs_tmo_cnt got=%0d exp=21", commit_cnt0); end
    endtask

    task automatic test_progress_timeout;
        logic seen;
        do_reset(32'd20);
        for (int c = 0; c <= 73; c++) begin
            commit_valid = (c < 50) ? 8'h01 : 8'h00;
            checks++; if (done1 !== logic'(c >= 71)) begin errors++; $display("[TB] FAIL prog_tmo_done c=%0d got=%0b exp=%0b", c, done1, c >= 71); end
            tick();
        end
        commit_valid = '0;
        checks++; if (cause1 !== 2'b11) begin errors++; $display("[TB] FAIL prog_tmo_cause got=%b exp=11", cause1); end
        checks++; if (commit_cnt1 !== 4'd15) begin errors++; $display("[TB] FAIL cnt_saturate got=%0d exp=15", commit_cnt1); end
        // A zero timeout_cfg disables the timeout entirely.
        do_reset(32'd0);
        seen = 1'b0;
        repeat (1000) begin
            tick();
            if (done0 || done1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL tmo_disabled got=%0b exp=0", seen); end
    endtask

    task automatic test_simultaneous;
        do_reset(32'd0);
        err  = 3'b001;
        halt = 8'h01;
        tick();
        err = '0; halt = '0;
        checks++; if (done0 !== 1'b0) begin errors++; $display("[TB] FAIL sim_done_early got=%0b exp=0", done0); end
        checks++; if (cause0 !== 2'b10) begin errors++; $display("[TB] FAIL sim_cause got=%b exp=10", cause0); end
        checks++; if (pass0 !== 1'b0) begin errors++; $display("[TB] FAIL sim_pass got=%0b exp=0", pass0); end
        checks++; if (halt_ch0 !== 3'd0) begin errors++; $display("[TB] FAIL sim_halt_ch got=%0d exp=0", halt_ch0); end
        checks++; if (done1 !== 1'b1) begin errors++; $display("[TB] FAIL sim_nodrain_done got=%0b exp=1", done1); end
        checks++; if (pass1 !== 1'b0) begin errors++; $display("[TB] FAIL sim_nodrain_pass got=%0b exp=0", pass1); end
        repeat (4) tick();
        checks++; if (done0 !== 1'b0) begin errors++; $display("[TB] FAIL sim_done_c5 got=%0b exp=0", done0); end
        tick();
        checks++; if (done0 !== 1'b1) begin errors++; $display("[TB] FAIL sim_done_c6 got=%0b exp=1", done0); end
        checks++; if (err_src0 !== 3'b001) begin errors++; $display("[TB] FAIL sim_err_src got=%b exp=001", err_src0); end
    endtask

    task automatic test_reset_mid_drain;
        do_reset(32'd0);
        commit_valid = 8'hFF;
        err = 3'b010;
        tick();
        err = '0;
        tick();
        checks++; if (commit_cnt0 !== 32'd16) begin errors++; $display("[TB] FAIL popcount_cnt got=%0d exp=16", commit_cnt0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("[TB] FAIL mid_drain_done got=%0b exp=0", done0); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        commit_valid = '0;
        checks++; if (done0 !== 1'b0) begin errors++; $display("[TB] FAIL rst_drain_done got=%0b exp=0", done0); end
        checks++; if (cause0 !== 2'b00) begin errors++; $display("[TB] FAIL rst_drain_cause got=%b exp=00", cause0); end
        checks++; if (err_src0 !== 3'b000) begin errors++; $display("[TB] FAIL rst_drain_err_src got=%b exp=000", err_src0); end
        checks++; if (commit_cnt0 !== 32'd0) begin errors++; $display("[TB] FAIL rst_drain_cnt got=%0d exp=0", commit_cnt0); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("[TB] FAIL rst_done_state got=%0b exp=0", done1); end
        halt = 8'h80;
        tick();
        halt = '0;
        checks++; if (done0 !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_done got=%0b exp=1", done0); end
        checks++; if (pass0 !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_pass got=%0b exp=1", pass0); end
        checks++; if (cause0 !== 2'b01) begin errors++; $display("[TB] FAIL post_rst_cause got=%b exp=01", cause0); end
        checks++; if (halt_ch0 !== 3'd7) begin errors++; $display("[TB] FAIL post_rst_halt_ch got=%0d exp=7", halt_ch0); end
        checks++; if (pass1 !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_pass1 got=%0b exp=1", pass1); end
    endtask

    initial begin
        rst = 1'b1; timeout_cfg = '0; commit_valid = '0; halt = '0; err = '0;
        test_reset();
        test_halt();
        test_error_drain();
        test_abs_timeout();
        test_progress_timeout();
        test_simultaneous();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
